cond_logic: RTL and testbench

Conditional-execution stage that sits directly downstream of the `alu`. It captures the ALU's `ALUFlags` (N,Z,C,V) into an architectural flag register under decoder control. It evaluates the 4-bit ARM condition field of the current instruction against the stored flags, and gates the decoder's PC, register and memory write strobes. A saturating counter of squashed (condition-failed) instructions is kept for debug.

---
 rtl/cond_logic_if.sv | 29 ++
 rtl/cond_logic.sv | 71 +++++++
 tb/tb_cond_logic.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cond_logic_if.sv
// Decoder/ALU-side bundle for the conditional-execution stage: instruction
// controls and flags in, gated write strobes and debug state out.
interface cond_logic_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SquashCnt;

  modport master (
    output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, SquashCnt
  );

  modport slave (
    input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, SquashCnt
  );
endinterface

// File: rtl/cond_logic.sv
// ARM-style conditional execution: holds the architectural NZCV register,
// gates decoder write strobes by the condition and counts squashed instructions.
module cond_logic #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  cond_logic_if.slave bus
);

  logic [3:0]       flags_p0;
  logic [CNT_W-1:0] squash_p0;
  logic             condex;
  logic             pass_vld;

  // Condition is judged against the stored flags only; ALUFlags is never bypassed.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cf;
      4'b0011: cond_eval = ~cf;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cf & ~z;
      4'b1001: cond_eval = ~cf | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      default: cond_eval = 1'b1;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    sat_inc = (&x) ? x : x + CNT_W'(1);
  endfunction

  assign condex   = cond_eval(bus.Cond, flags_p0);
  assign pass_vld = bus.en & condex;

  // Stage p0: architectural flags and squash counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_p0  <= 4'b0000;
      squash_p0 <= '0;
    end else if (bus.en) begin
      if (condex) begin
        if (bus.FlagW[1]) flags_p0[3:2] <= bus.ALUFlags[3:2];
        if (bus.FlagW[0]) flags_p0[1:0] <= bus.ALUFlags[1:0];
      end else begin
        squash_p0 <= sat_inc(squash_p0);
      end
    end
  end

  assign bus.CondEx    = condex;
  assign bus.PCSrc     = bus.PCS  & pass_vld;
  assign bus.RegWrite  = bus.RegW & pass_vld;
  assign bus.MemWrite  = bus.MemW & pass_vld;
  assign bus.Flags     = flags_p0;
  assign bus.SquashCnt = squash_p0;

endmodule

// File: tb/tb_cond_logic.sv
// Directed-vector bench for cond_logic: table of single-cycle instructions plus
// hand-written reset, stall and saturation sequences.
module tb_cond_logic;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  cond_logic_if #(.CNT_W(CNT_W)) bus ();

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs, regw, memw;
    logic       ex, pc, rw, mw;
    logic [3:0] fl;
    logic [3:0] cnt;
  } vec_t;

  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(string name, logic en, logic [3:0] cond, logic [3:0] alu,
                              logic [1:0] fw, logic pcs, logic regw, logic memw,
                              logic ex, logic pc, logic rw, logic mw,
                              logic [3:0] fl, logic [3:0] cnt);
    vec_t v;
    v.name = name; v.en = en; v.cond = cond; v.alu = alu; v.fw = fw;
    v.pcs = pcs; v.regw = regw; v.memw = memw;
    v.ex = ex; v.pc = pc; v.rw = rw; v.mw = mw; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] cond, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic regw, input logic memw);
    bus.en = en; bus.Cond = cond; bus.ALUFlags = alu; bus.FlagW = fw;
    bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw;
  endtask

  initial begin
    //          name        en cond     alu      fw    pcs rw mw  ex pc rw mw  flags    cnt
    vt.push_back(mk("sub5m5_al", 1, 4'b1110, 4'b0110, 2'b11, 1, 1, 1,  1, 1, 1, 1,  4'b0110, 4'd0));
    vt.push_back(mk("eq_pass",   1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0,  1, 0, 1, 0,  4'b0110, 4'd0));
    vt.push_back(mk("ne_fail",   1, 4'b0001, 4'b0000, 2'b00, 0, 1, 0,  0, 0, 0, 0,  4'b0110, 4'd1));
    vt.push_back(mk("ne_sqflag", 1, 4'b0001, 4'b1111, 2'b11, 0, 0, 1,  0, 0, 0, 0,  4'b0110, 4'd2));
    vt.push_back(mk("part_nz",   1, 4'b1110, 4'b1001, 2'b10, 0, 0, 0,  1, 0, 0, 0,  4'b1010, 4'd2));
    vt.push_back(mk("lt_pass",   1, 4'b1011, 4'b0000, 2'b00, 0, 1, 0,  1, 0, 1, 0,  4'b1010, 4'd2));
    vt.push_back(mk("gt_fail",   1, 4'b1100, 4'b0000, 2'b00, 0, 1, 0,  0, 0, 0, 0,  4'b1010, 4'd3));
    vt.push_back(mk("add_zero",  1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0,  1, 0, 0, 0,  4'b0000, 4'd3));
    vt.push_back(mk("hi_fail",   1, 4'b1000, 4'b0000, 2'b00, 1, 0, 0,  0, 0, 0, 0,  4'b0000, 4'd4));
    vt.push_back(mk("ls_pass",   1, 4'b1001, 4'b0000, 2'b00, 1, 0, 0,  1, 1, 0, 0,  4'b0000, 4'd4));
    vt.push_back(mk("ge_pass",   1, 4'b1010, 4'b0000, 2'b00, 0, 0, 1,  1, 0, 0, 1,  4'b0000, 4'd4));
    vt.push_back(mk("pl_pass",   1, 4'b0101, 4'b0000, 2'b00, 0, 1, 0,  1, 0, 1, 0,  4'b0000, 4'd4));
    vt.push_back(mk("stall_eq",  0, 4'b0000, 4'b1111, 2'b11, 1, 1, 1,  0, 0, 0, 0,  4'b0000, 4'd4));
    vt.push_back(mk("stall_al",  0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1,  1, 0, 0, 0,  4'b0000, 4'd4));
    vt.push_back(mk("part_cv",   1, 4'b1110, 4'b0101, 2'b01, 0, 0, 0,  1, 0, 0, 0,  4'b0001, 4'd4));
    vt.push_back(mk("vs_pass",   1, 4'b0110, 4'b0000, 2'b00, 0, 1, 0,  1, 0, 1, 0,  4'b0001, 4'd4));
    vt.push_back(mk("mi_fail",   1, 4'b0100, 4'b0000, 2'b00, 0, 1, 0,  0, 0, 0, 0,  4'b0001, 4'd5));
    vt.push_back(mk("vc_fail",   1, 4'b0111, 4'b0000, 2'b00, 0, 1, 0,  0, 0, 0, 0,  4'b0001, 4'd6));
    vt.push_back(mk("cs_fail",   1, 4'b0010, 4'b0000, 2'b00, 0, 1, 0,  0, 0, 0, 0,  4'b0001, 4'd7));
    vt.push_back(mk("cc_pass",   1, 4'b0011, 4'b0000, 2'b00, 0, 1, 0,  1, 0, 1, 0,  4'b0001, 4'd7));
    vt.push_back(mk("le_pass",   1, 4'b1101, 4'b0000, 2'b00, 0, 1, 0,  1, 0, 1, 0,  4'b0001, 4'd7));
    vt.push_back(mk("nv_pass",   1, 4'b1111, 4'b0000, 2'b00, 1, 1, 1,  1, 1, 1, 1,  4'b0001, 4'd7));

    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);

    // Reset state and combinational condition against cleared flags
    #3;
    chk("rst_flags", 32'(bus.Flags), 32'h0);
    chk("rst_cnt", 32'(bus.SquashCnt), 32'h0);
    chk("rst_eq_condex", 32'(bus.CondEx), 32'h0);
    bus.Cond = 4'b0001;
    #1;
    chk("rst_ne_condex", 32'(bus.CondEx), 32'h1);
    bus.Cond = 4'b1110;
    #1;
    chk("rst_al_condex", 32'(bus.CondEx), 32'h1);

    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].cond, vt[i].alu, vt[i].fw, vt[i].pcs, vt[i].regw, vt[i].memw);
      #1;
      chk({vt[i].name, ".CondEx"},   32'(bus.CondEx),   32'(vt[i].ex));
      chk({vt[i].name, ".PCSrc"},    32'(bus.PCSrc),    32'(vt[i].pc));
      chk({vt[i].name, ".RegWrite"}, 32'(bus.RegWrite), 32'(vt[i].rw));
      chk({vt[i].name, ".MemWrite"}, 32'(bus.MemWrite), 32'(vt[i].mw));
      @(posedge clk);
      #1;
      chk({vt[i].name, ".Flags"},     32'(bus.Flags),     32'(vt[i].fl));
      chk({vt[i].name, ".SquashCnt"}, 32'(bus.SquashCnt), 32'(vt[i].cnt));
    end

    // Async reset between edges: state clears before the next edge, pending write lost
    drive(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_flags", 32'(bus.Flags), 32'h0);
    chk("async_cnt", 32'(bus.SquashCnt), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_edge_flags", 32'(bus.Flags), 32'h0);
    bus.Cond = 4'b0000;
    #1;
    chk("rst_edge_eq", 32'(bus.CondEx), 32'h0);
    reset = 1'b0;

    // Saturation: flags are 0000, so EQ fails every cycle
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) @(posedge clk);
    #1;
    chk("sat_cnt14", 32'(bus.SquashCnt), 32'd14);
    for (int k = 0; k < 6; k++) @(posedge clk);
    #1;
    chk("sat_cnt20", 32'(bus.SquashCnt), 32'd15);

    // Stall holds a saturated counter and flags
    drive(1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("stall_cnt", 32'(bus.SquashCnt), 32'd15);
    chk("stall_flags", 32'(bus.Flags), 32'h0);
    chk("stall_regwrite", 32'(bus.RegWrite), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
